ucsbece154b_state_checker: RTL

Parametrised, synthesizable end-of-program checker for the pipelined RISC-V core. It is loaded with a table of expected register and data-memory values, runs the program until a halt event or a cycle timeout, then reads each listed location through a request/response probe port and compares it. It reports pass/fail, the failure count and the first failing entry, and replaces the fixed-cycle, hard-coded assertion sequence in top-level benches. It sits beside `ucsbece154b_top`, wired to a debug read port on the register file and data memory.

---
 rtl/ucsbece154b_checker_pkg.sv | 40 ++++
 rtl/ucsbece154b_state_checker_if.sv | 35 +++
 rtl/ucsbece154b_checker_table.sv | 47 ++++
 rtl/ucsbece154b_state_checker.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154b_checker_pkg.sv
// ucsbece154b_checker_pkg
//   Shared types for the end-of-program state checker.
//   - checker_state_e : IDLE -> RUN -> CHECK -> DONE
//   - check_entry_t   : one expected-value table entry
//   - entry_match     : compare helper (masked when UCSBECE154B_CHECKER_MASK_EN is defined)
//   Optional feature macro: UCSBECE154B_CHECKER_MASK_EN adds a per-entry compare mask.
package ucsbece154b_checker_pkg;

    localparam int unsigned DataWidth = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StCheck,
        StDone
    } checker_state_e;

    typedef struct packed {
        logic                 is_mem;
        logic [DataWidth-1:0] addr;
        logic [DataWidth-1:0] data;
`ifdef UCSBECE154B_CHECKER_MASK_EN
        logic [DataWidth-1:0] mask;
`endif
    } check_entry_t;

    // Index width for an n-entry table; a 1-entry table still gets a 1-bit index.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic entry_match(check_entry_t e, logic [DataWidth-1:0] d);
`ifdef UCSBECE154B_CHECKER_MASK_EN
        return ((d ^ e.data) & e.mask) == '0;
`else
        return d == e.data;
`endif
    endfunction

endpackage

// File: rtl/ucsbece154b_state_checker_if.sv
// ucsbece154b_state_checker_if
//   Probe request/response channel between the checker and the debug read port
//   of the register file / data memory.
//   - probe_valid  : request valid (checker -> target)
//   - probe_is_mem : 1 = data-memory word, 0 = register
//   - probe_addr   : byte address or register number in [4:0]
//   - probe_rdy    : response valid, may be high in the same cycle as the request
//   - probe_data   : response data
//   Modports: master (checker side), slave (register file / memory side).
interface ucsbece154b_state_checker_if;
    import ucsbece154b_checker_pkg::*;

    logic                 probe_valid;
    logic                 probe_is_mem;
    logic [DataWidth-1:0] probe_addr;
    logic                 probe_rdy;
    logic [DataWidth-1:0] probe_data;

    modport master (
        output probe_valid,
        output probe_is_mem,
        output probe_addr,
        input  probe_rdy,
        input  probe_data
    );

    modport slave (
        input  probe_valid,
        input  probe_is_mem,
        input  probe_addr,
        output probe_rdy,
        output probe_data
    );

endinterface

// File: rtl/ucsbece154b_checker_table.sv
// ucsbece154b_checker_table
//   NUM_CHECKS-entry register array of expected values.
//   - clk    : clock
//   - we     : synchronous write enable
//   - widx   : write index
//   - wentry : entry to write
//   - ridx   : asynchronous read index
//   - rentry : entry at ridx (zero for indices beyond NUM_CHECKS)
//   Contents are deliberately not reset. Mask storage exists only when
//   UCSBECE154B_CHECKER_MASK_EN is defined (it lives inside check_entry_t).
module ucsbece154b_checker_table
    import ucsbece154b_checker_pkg::*;
#(
    parameter  int unsigned NUM_CHECKS = 16,
    localparam int unsigned IW         = idx_width(NUM_CHECKS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  check_entry_t  wentry,
    input  logic [IW-1:0] ridx,
    output check_entry_t  rentry
);

    check_entry_t entries_q [NUM_CHECKS];

    if (NUM_CHECKS == (1 << IW)) begin : g_full
        // Every index value addresses a real entry.
        always_ff @(posedge clk) begin
            if (we) begin
                entries_q[widx] <= wentry;
            end
        end

        assign rentry = entries_q[ridx];
    end else begin : g_part
        // Index space is larger than the table; drop out-of-range accesses.
        always_ff @(posedge clk) begin
            if (we && (32'(widx) < NUM_CHECKS)) begin
                entries_q[widx] <= wentry;
            end
        end

        assign rentry = (32'(ridx) < NUM_CHECKS) ? entries_q[ridx] : '0;
    end

endmodule

// File: rtl/ucsbece154b_state_checker.sv
// ucsbece154b_state_checker
//   End-of-program checker for the pipelined RISC-V core. A table of expected
//   register / data-memory values is loaded in IDLE; after start the program runs
//   until halt or TIMEOUT_CYCLES, then every listed location is read through the
//   probe port and compared.
//   Parameters: NUM_CHECKS (table depth), TIMEOUT_CYCLES (max RUN cycles).
//   Ports:
//   - clk, reset           : clock, synchronous active-high reset
//   - cfg_we/idx/is_mem/addr/data/mask : table write port (IDLE only)
//   - cfg_count            : number of valid entries, latched on start (saturates)
//   - start, halt          : leave IDLE / DONE; program finished
//   - probe                : request/response channel (master modport)
//   - done, pass, timed_out, fail_count, first_fail_idx : registered results
//   Optional feature macro: UCSBECE154B_CHECKER_MASK_EN enables masked compares;
//   without it cfg_mask is unused and compares are full 32-bit equality.
module ucsbece154b_state_checker
    import ucsbece154b_checker_pkg::*;
#(
    parameter  int unsigned NUM_CHECKS     = 16,
    parameter  int unsigned TIMEOUT_CYCLES = 100,
    localparam int unsigned IW             = idx_width(NUM_CHECKS),
    localparam int unsigned CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [IW-1:0]        cfg_idx,
    input  logic                 cfg_is_mem,
    input  logic [DataWidth-1:0] cfg_addr,
    input  logic [DataWidth-1:0] cfg_data,
    input  logic [DataWidth-1:0] cfg_mask,
    input  logic [IW:0]          cfg_count,
    input  logic                 start,
    input  logic                 halt,
    ucsbece154b_state_checker_if.master probe,
    output logic                 done,
    output logic                 pass,
    output logic                 timed_out,
    output logic [IW:0]          fail_count,
    output logic [IW-1:0]        first_fail_idx
);

    localparam logic [IW:0]   NumChecksW   = (IW + 1)'(NUM_CHECKS);
    localparam logic [IW:0]   OneIdx       = (IW + 1)'(1);
    localparam logic [CW-1:0] LastRunCycle = CW'(TIMEOUT_CYCLES - 1);

    checker_state_e state_q, state_d;
    logic [IW:0]    count_q, count_d;
    logic [CW-1:0]  cycle_q, cycle_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW:0]    fail_q, fail_d;
    logic [IW-1:0]  ffi_q, ffi_d;
    logic           timed_out_q, timed_out_d;
    logic           done_q, done_d;
    logic           pass_q, pass_d;

    check_entry_t   wr_entry;
    check_entry_t   rd_entry;
    logic           table_we;
    logic           last_entry;
    logic           mismatch;

    // ------------------------------------------------------------------
    // Expected-value table
    // ------------------------------------------------------------------
    always_comb begin
        wr_entry        = '0;
        wr_entry.is_mem = cfg_is_mem;
        wr_entry.addr   = cfg_addr;
        wr_entry.data   = cfg_data;
`ifdef UCSBECE154B_CHECKER_MASK_EN
        wr_entry.mask   = cfg_mask;
`endif
    end

`ifndef UCSBECE154B_CHECKER_MASK_EN
    logic unused_cfg_mask;
    assign unused_cfg_mask = ^cfg_mask;
`endif

    assign table_we = cfg_we && (state_q == StIdle);

    ucsbece154b_checker_table #(
        .NUM_CHECKS (NUM_CHECKS)
    ) u_table (
        .clk    (clk),
        .we     (table_we),
        .widx   (cfg_idx),
        .wentry (wr_entry),
        .ridx   (ptr_q),
        .rentry (rd_entry)
    );

    // ------------------------------------------------------------------
    // Probe request decodes straight from state and pointer
    // ------------------------------------------------------------------
    assign probe.probe_valid  = (state_q == StCheck) && (count_q != '0);
    assign probe.probe_is_mem = rd_entry.is_mem;
    assign probe.probe_addr   = rd_entry.addr;

    assign last_entry = (({1'b0, ptr_q} + OneIdx) == count_q);
    assign mismatch   = !entry_match(rd_entry, probe.probe_data);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        cycle_d     = cycle_q;
        ptr_d       = ptr_q;
        fail_d      = fail_q;
        ffi_d       = ffi_q;
        timed_out_d = timed_out_q;
        done_d      = done_q;
        pass_d      = pass_q;

        unique case (state_q)
            StIdle, StDone: begin
                // From DONE, start re-arms with whatever the table already holds.
                if (start) begin
                    state_d     = StRun;
                    count_d     = (cfg_count > NumChecksW) ? NumChecksW : cfg_count;
                    cycle_d     = '0;
                    ptr_d       = '0;
                    fail_d      = '0;
                    ffi_d       = '0;
                    timed_out_d = 1'b0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                end
            end

            StRun: begin
                cycle_d = cycle_q + CW'(1);
                // Halt has priority over a coincident timeout.
                if (halt) begin
                    state_d = StCheck;
                end else if (cycle_q == LastRunCycle) begin
                    state_d     = StCheck;
                    timed_out_d = 1'b1;
                end
            end

            StCheck: begin
                if (count_q == '0) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    pass_d  = !timed_out_q;
                end else if (probe.probe_rdy) begin
                    if (mismatch) begin
                        fail_d = fail_q + OneIdx;
                        if (fail_q == '0) begin
                            ffi_d = ptr_q;
                        end
                    end
                    if (last_entry) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        pass_d  = (fail_d == '0) && !timed_out_q;
                    end else begin
                        ptr_d = ptr_q + IW'(1);
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers (table contents are outside this reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            cycle_q     <= '0;
            ptr_q       <= '0;
            fail_q      <= '0;
            ffi_q       <= '0;
            timed_out_q <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            cycle_q     <= cycle_d;
            ptr_q       <= ptr_d;
            fail_q      <= fail_d;
            ffi_q       <= ffi_d;
            timed_out_q <= timed_out_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign done           = done_q;
    assign pass           = pass_q;
    assign timed_out      = timed_out_q;
    assign fail_count     = fail_q;
    assign first_fail_idx = ffi_q;

endmodule
